// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a byte stream over a valid/ready handshake: a 4-byte little-endian
// word count N, then N little-endian 32-bit words. Each word is written to
// instruction memory in turn, starting at BASE_ADDR.
// The core stays held until a complete image has been loaded.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the last word, one more
// byte is accepted. It must equal the XOR of all payload bytes, otherwise the
// load is reported as an error.

`timescale 1ns/1ps

module imem_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_CHECK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift_reg;
  logic [31:0]      shift_next;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] word_idx_inc;
  logic [IDX_W-1:0] word_cnt;
  logic             loaded;
  logic             xfer;
  logic             last_byte;
  logic             len_too_big;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // The three most recent bytes plus the incoming one form the little-endian word.
  assign xfer         = byte_valid & byte_ready;
  assign last_byte    = (byte_cnt == 2'd3);
  assign shift_next   = {byte_data, shift_reg};
  assign word_idx_inc = word_idx + IDX_W'(1);
  assign len_too_big  = (shift_next > 32'(MAX_WORDS));
  assign busy         = (state != S_IDLE);
  assign cpu_hold     = ~loaded | busy;

  // State register; reset abandons any load in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and per-state handshake/strobe outputs.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        byte_ready = 1'b1;
        if (xfer && last_byte) begin
          if (shift_next == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = S_CHECK;
`else
            state_next = S_DONE;
`endif
          end else if (len_too_big) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (xfer && last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        if (word_idx_inc == word_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (xfer) state_next = (byte_data == csum) ? S_DONE : S_IDLE;
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, counters, write address/data, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      shift_reg  <= 24'd0;
      word_idx   <= '0;
      word_cnt   <= '0;
      loaded     <= 1'b0;
      err        <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      if (state == S_IDLE && start) begin
        err      <= 1'b0;
        byte_cnt <= 2'd0;
        word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end

      if (xfer) begin
        byte_cnt  <= byte_cnt + 2'd1;
        shift_reg <= shift_next[31:8];
      end

      if (state == S_LEN && xfer && last_byte) begin
        word_cnt <= shift_next[IDX_W-1:0];
        if (len_too_big) err <= 1'b1;
      end

      if (state == S_DATA && xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ byte_data;
`endif
        if (last_byte) begin
          imem_addr  <= BASE_ADDR + (ADDR_W'(word_idx) << 2);
          imem_wdata <= shift_next;
        end
      end

      if (state == S_WRITE) word_idx <= word_idx_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == S_CHECK && xfer && byte_data != csum) err <= 1'b1;
`endif

      if (state == S_DONE) loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed byte streams, with a write scoreboard
// that is filled when words are driven and drained by the imem_we monitor.

`timescale 1ns/1ps

module tb_imem_loader;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          MAX_WORDS = 64;

  logic              clk;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic        prev_xfer = 1'b0;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports and counts a miss.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (imem_we) begin
      checkOutput("we_after_xfer", 64'(prev_xfer), 64'd1);
      checkOutput("ready_in_write", 64'(byte_ready), 64'd0);
      checkOutput("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) checkOutput("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
    prev_xfer = byte_valid & byte_ready;
  end

  // Offer one byte (call just after a rising edge) and check how many cycles it waited.
  task automatic applyStimulus(input logic [7:0] b, input bit gap, input int exp_wait);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    do begin
      @(negedge clk);
      t++;
    end while (byte_ready !== 1'b1 && t < 50);
    checkOutput("accept_wait", 64'(t), 64'(exp_wait));
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for the done pulse, then check the release of the core.
  task automatic waitDone();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done !== 1'b1 && t < 10);
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("busy_in_done", 64'(busy), 64'd1);
    checkOutput("hold_in_done", 64'(cpu_hold), 64'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("hold_after_done", 64'(cpu_hold), 64'd0);
    checkOutput("err_after_done", 64'(err), 64'd0);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Count, payload (scoreboard filled as words are driven) and optional checksum.
  task automatic sendBody(input int n, input logic [31:0] w0, input logic [31:0] w1, input bit gaps);
    logic [31:0] nv;
    logic [31:0] w;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  x;
    x = 8'h00;
`endif
    nv = 32'(n);
    for (int i = 0; i < 4; i++) applyStimulus(nv[8*i +: 8], gaps, 1);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      exp_q.push_back({BASE_ADDR + 32'(4 * k), w});
      for (int i = 0; i < 4; i++) begin
        applyStimulus(w[8*i +: 8], gaps && (i != 3), (k > 0 && i == 0) ? 2 : 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = x ^ w[8*i +: 8];
`endif
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(x, 1'b0, (n > 0) ? 2 : 1);
`endif
    waitDone();
  endtask

  task automatic sendImage(input int n, input logic [31:0] w0, input logic [31:0] w1, input bit gaps);
    pulseStart();
    sendBody(n, w0, w1, gaps);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 64'(byte_ready), 64'd0);
    checkOutput({tag, "_we"}, 64'(imem_we), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    checkOutput({tag, "_addr"}, 64'(imem_addr), 64'(BASE_ADDR));
    checkOutput({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
  endtask

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset for two cycles, then idle with the core held.
    @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_hold", 64'(cpu_hold), 64'd1);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_ready", 64'(byte_ready), 64'd0);
      checkOutput("idle_we", 64'(imem_we), 64'd0);
    end

    // Two-word image, back-to-back bytes.
    $display("[TB] two-word image, continuous valid");
    sendImage(2, 32'h0010_0513, 32'h0020_0593, 1'b0);

    // Same image, valid toggling; byte after each word is offered during WRITE.
    $display("[TB] two-word image, toggling valid");
    sendImage(2, 32'h0010_0513, 32'h0020_0593, 1'b1);

    // Empty image completes directly.
    $display("[TB] zero-length image");
    sendImage(0, 32'h0, 32'h0, 1'b0);

    // Oversize count: error, no writes, back to idle; prior load keeps core running.
    $display("[TB] oversize count");
    pulseStart();
    applyStimulus(8'h41, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    @(negedge clk);
    checkOutput("oversize_err", 64'(err), 64'd1);
    checkOutput("oversize_busy", 64'(busy), 64'd0);
    checkOutput("oversize_ready", 64'(byte_ready), 64'd0);
    checkOutput("oversize_hold", 64'(cpu_hold), 64'd0);
    @(negedge clk);
    checkOutput("oversize_err_sticky", 64'(err), 64'd1);
    pulseStart();
    @(negedge clk);
    checkOutput("restart_err_clear", 64'(err), 64'd0);
    checkOutput("restart_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    sendBody(2, 32'h0010_0513, 32'h0020_0593, 1'b0);

    // Reset after the second payload byte, then a fresh load from BASE_ADDR.
    $display("[TB] reset mid-load");
    pulseStart();
    applyStimulus(8'h02, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h13, 1'b0, 1);
    applyStimulus(8'h05, 1'b0, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetValues("midload_reset");
    rst = 1'b0;
    sendImage(2, 32'h0010_0513, 32'h0020_0593, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good (0x06) then bad (0x07) for one word 13 05 10 00.
    $display("[TB] checksum match");
    pulseStart();
    applyStimulus(8'h01, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    exp_q.push_back({BASE_ADDR, 32'h0010_0513});
    applyStimulus(8'h13, 1'b0, 1);
    applyStimulus(8'h05, 1'b0, 1);
    applyStimulus(8'h10, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h06, 1'b0, 2);
    waitDone();

    $display("[TB] checksum mismatch");
    pulseStart();
    applyStimulus(8'h01, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    exp_q.push_back({BASE_ADDR, 32'h0010_0513});
    applyStimulus(8'h13, 1'b0, 1);
    applyStimulus(8'h05, 1'b0, 1);
    applyStimulus(8'h10, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h07, 1'b0, 2);
    @(negedge clk);
    checkOutput("csum_err", 64'(err), 64'd1);
    checkOutput("csum_no_done", 64'(done), 64'd0);
    checkOutput("csum_busy", 64'(busy), 64'd0);
    checkOutput("csum_hold", 64'(cpu_hold), 64'd0);
    @(negedge clk);
    checkOutput("csum_no_done_later", 64'(done), 64'd0);
    checkOutput("csum_queue_drained", 64'(exp_q.size()), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle core fetches from.
- Accepts a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Holds the core in reset/stall until a complete image is loaded.

Parameters:
- ADDR_W, 32, width of imem_addr (byte address).
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 64, largest accepted image size in words (instruction memory depth).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load when idle
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle (transfer = byte_valid & byte_ready)
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word-aligned byte address of the write
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  1 = core must stay stalled/reset
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag, cleared by next accepted start

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0, cpu_hold=1.
  - Internal loaded flag resets to 0.
  - Byte counter and word counter reset to 0.
- cpu_hold = ~loaded | busy. The core never runs before the first successful load.
- Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, each word little-endian (first byte is bits [7:0]).
- IDLE state:
  - byte_ready=0, busy=0.
  - start=1 -> LEN. This clears err, clears the counters and sets busy=1 from the next cycle.
- LEN state:
  - byte_ready=1; collect 4 bytes into N.
  - On the 4th transfer:
    - N=0 -> DONE.
    - N>MAX_WORDS -> set err and go to IDLE. loaded is unchanged.
    - Otherwise -> DATA.
- DATA state:
  - byte_ready=1; shift bytes into the word register.
  - On the 4th transfer -> WRITE.
- WRITE state (exactly one cycle):
  - byte_ready=0, imem_we=1.
  - imem_addr = BASE_ADDR + 4*word_idx, computed modulo 2^ADDR_W.
  - imem_wdata = assembled word.
  - word_idx increments. Then word_idx==N -> DONE (or CHECK when the option is enabled); otherwise -> DATA.
- Word latency: imem_we asserts the cycle after the 4th byte transfer of that word.
- DONE state (one cycle):
  - done=1, loaded set to 1.
  - Next cycle -> IDLE; busy=0 and cpu_hold=0 from that cycle.
- byte_valid while byte_ready=0: byte is not consumed. The source must hold it; no data is lost.
- start while busy: ignored.
- rst mid-load: aborts immediately to reset values, including loaded=0 (cpu_hold=1).
  - Memory contents already written are not undone.
- Errored load: imem may be partially rewritten. cpu_hold stays 1 if no previous load succeeded; a prior good load keeps loaded=1.
- imem_addr holds its last value when imem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHECK (byte_ready=1) and accept one byte.
  - Compare it with the XOR of all 4*N payload bytes (count bytes excluded).
  - Match -> DONE. Mismatch -> err=1, then IDLE with loaded unchanged.
  - N=0 still goes through CHECK, with expected value 8'h00.
- Not defined: no CHECK state; the last WRITE goes directly to DONE.

Test Plan:
1. After reset, hold rst 2 cycles, then idle 5 cycles -> cpu_hold=1, busy=0, byte_ready=0, imem_we=0 throughout.
2. start, then stream 02 00 00 00, 13 05 10 00, 93 05 20 00 with byte_valid held high -> two imem_we pulses:
   - addr 0x0, data 0x00100513;
   - addr 0x4, data 0x00200593;
   - one done pulse, cpu_hold=0 on the cycle after done.
3. Same image with byte_valid toggling 1/0 every cycle and a byte offered during the WRITE cycle -> identical writes. That byte is accepted only after WRITE.
4. Count bytes 41 00 00 00 (65 > MAX_WORDS) -> err=1, no imem_we, return to IDLE.
   - Then a valid start clears err.
5. Assert rst after the 2nd payload byte -> all outputs at reset values the next cycle, cpu_hold=1. A fresh load then succeeds from addr BASE_ADDR.
6. With IMEM_LOADER_CHECKSUM_EN, N=1, word 13 05 10 00:
   - checksum byte 0x06 -> done=1;
   - checksum byte 0x07 -> err=1, no done, loaded unchanged.
